int32_to_fp32: RTL

INT32_TO_FP32 -- requirements
Module: int32_to_fp32

---
 rtl/int32_to_fp32.sv | 126 ++++++++++++
 1 files changed

// File: rtl/int32_to_fp32.sv
// Multi-cycle 32-bit integer (signed/unsigned) to IEEE-754 single-precision converter.
// Optional ROUND_NEAREST_EN selects round-to-nearest-even; otherwise the result is truncated.
module int32_to_fp32 #(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_signed,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

    state_t      state, state_nxt;
    logic        sign_q;
    logic [31:0] mag_q;
    logic [7:0]  exp_q;
    logic [31:0] out_data_q;

    logic signed [31:0] in_data_s;
    logic               in_neg;
    logic [31:0]        in_mag;
    logic               accept;
    logic [3:0]         norm_sh;
    logic               lead_one;
    logic               round_up;

    // Negating 0x80000000 wraps back to itself, which is the correct magnitude 2^31.
    assign in_data_s = in_data;
    assign in_neg    = in_signed & in_data[31];
    assign in_mag    = in_neg ? 32'(-in_data_s) : in_data;
    assign accept    = in_valid && in_ready;

    function automatic logic [30:0] round_pack(input logic [7:0] e, input logic [22:0] frac,
                                               input logic inc);
        // A carry out of the fraction ripples into the exponent and clears the fraction.
        return {e, frac} + {30'd0, inc};
    endfunction

`ifdef ROUND_NEAREST_EN
    function automatic logic rne_round_up(input logic lsb, input logic guard, input logic sticky);
        return guard & (sticky | lsb);
    endfunction

    assign round_up = rne_round_up(mag_q[8], mag_q[7], |mag_q[6:0]);
`else
    logic unused_grs;
    assign round_up   = 1'b0;
    assign unused_grs = ^mag_q[7:0];
`endif

    // Shift amount for this NORM cycle: leading zeros, capped at BITS_PER_CYCLE.
    always_comb begin
        norm_sh  = '0;
        lead_one = 1'b0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (mag_q[31-i])
                lead_one = 1'b1;
            else if (!lead_one)
                norm_sh = norm_sh + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = (in_mag == 32'd0) ? DONE : NORM;
            NORM:    if (mag_q[31]) state_nxt = ROUND;
            ROUND:   state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
        out_data  = out_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_q     <= 1'b0;
            mag_q      <= '0;
            exp_q      <= '0;
            out_data_q <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        sign_q <= in_neg;
                        mag_q  <= in_mag;
                        exp_q  <= 8'd158;
                        if (in_mag == 32'd0)
                            out_data_q <= '0;
                    end
                end
                NORM: begin
                    if (!mag_q[31]) begin
                        mag_q <= mag_q << norm_sh;
                        exp_q <= exp_q - {4'd0, norm_sh};
                    end
                end
                ROUND: begin
                    out_data_q <= {sign_q, round_pack(exp_q, mag_q[30:8], round_up)};
                end
                default: ;
            endcase
        end
    end

endmodule
